// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch responder.
package fetch_pkg;

   typedef logic [31:0] instr_t;

   // addi x0, x0, 0 -- used to fill unused program memory
   localparam instr_t NOP = 32'h0000_0013;

   localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

endpackage

// File: rtl/instr_fetch_responder_if.sv
// Fetch request, response and program-load signals between core and fetch responder.
interface instr_fetch_responder_if
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = 32
);

   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  flush;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_instr;
   logic [ADDR_WIDTH-1:0] rsp_addr;
   logic                  prog_we;
   logic [ADDR_WIDTH-1:0] prog_addr;
   logic [DATA_WIDTH-1:0] prog_data;

   // Core side: issues fetches and program loads, consumes responses.
   modport master (
      output req_valid, req_addr, flush, rsp_ready, prog_we, prog_addr, prog_data,
      input  req_ready, rsp_valid, rsp_instr, rsp_addr
   );

   // Responder side.
   modport slave (
      input  req_valid, req_addr, flush, rsp_ready, prog_we, prog_addr, prog_data,
      output req_ready, rsp_valid, rsp_instr, rsp_addr
   );

endinterface

// File: rtl/rsp_fifo.sv
// Synchronous FIFO holding fetch responses; clr_i empties it in one edge.
module rsp_fifo #(
   parameter int unsigned DEPTH = 3,
   parameter int unsigned WIDTH = 37
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

   logic [WIDTH-1:0] store_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   // Pointer/count next state; clear dominates push and pop.
   always_comb begin
      do_push  = push_i && (count_q < FullCnt);
      do_pop   = pop_i && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   // State and storage; storage reset so an empty head reads as zero after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push && !clr_i) store_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = store_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: program memory, S1 read register and response FIFO.
module instr_fetch_responder
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RSP_DEPTH  = 3
) (
   input logic                    clk,
   input logic                    rst,
   instr_fetch_responder_if.slave bus
);

   localparam int unsigned MemDepth = 2 ** ADDR_WIDTH;
   localparam int unsigned CntW     = $clog2(RSP_DEPTH + 1);
   localparam int unsigned EntryW   = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CntW:0] DepthC = (CntW + 1)'(RSP_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [MemDepth];

   logic                  s1_valid_q, s1_valid_d;
   logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
   logic [DATA_WIDTH-1:0] s1_data_q;

   logic [CntW-1:0]       fifo_count;
   logic                  fifo_valid;
   logic [EntryW-1:0]     fifo_rdata;
   logic [CntW:0]         credit_used;
   logic                  req_ready;
   logic                  accept;

   // Credit check counts S1 as occupied so every S1 entry has a FIFO slot; pops give no
   // same-cycle credit, keeping rsp_ready off the req_ready path.
   always_comb begin
      credit_used = {1'b0, fifo_count} + {{CntW{1'b0}}, s1_valid_q};
      req_ready   = !bus.flush && (credit_used < DepthC);
      accept      = bus.req_valid && req_ready;
      s1_valid_d  = accept;
      s1_addr_d   = accept ? bus.req_addr : s1_addr_q;
   end

   // Program load and synchronous read into S1; the array itself is never reset and a
   // same-address write in the accept cycle leaves the read with the old word.
   always_ff @(posedge clk) begin
      if (bus.prog_we) mem_q[bus.prog_addr] <= bus.prog_data;
      if (accept)      s1_data_q <= mem_q[bus.req_addr];
   end

   // S1 control register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_addr_q  <= s1_addr_d;
      end
   end

   rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (EntryW)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (bus.flush),
      .push_i  (s1_valid_q),
      .data_i  ({s1_addr_q, s1_data_q}),
      .pop_i   (bus.rsp_ready),
      .data_o  (fifo_rdata),
      .valid_o (fifo_valid),
      .count_o (fifo_count)
   );

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = fifo_valid;
   assign bus.rsp_addr  = fifo_rdata[EntryW-1 -: ADDR_WIDTH];
   assign bus.rsp_instr = fifo_rdata[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Self-checking bench for instr_fetch_responder: directed scenarios plus random traffic
// against a queue-based model of accepted-but-unconsumed fetches.
module tb_instr_fetch_responder;
   import fetch_pkg::*;

   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_fetch_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   instr_fetch_responder #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RSP_DEPTH  (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   instr_t prog [4] = '{32'h0050_0093, 32'h00a0_0113, 32'h0020_81b3, 32'h0000_0013};

   // Model: memory image and an ordered list of fetches owed to the consumer.
   typedef struct {
      logic [AW-1:0] addr;
      instr_t        instr;
      int            acc;   // edge number at which the fetch was accepted
   } exp_t;

   instr_t mem_m [2**AW];
   exp_t   q [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: evaluated mid-cycle, applies the events of the coming edge to the model.
   always @(negedge clk) begin
      logic exp_ready, exp_valid;
      exp_t e;
      if (mon_en) begin
         if (rst) begin
            q.delete();
            checks++;
            if (bus.rsp_valid !== 1'b0) begin
               errors++; $display("FAIL mon_rst_rsp_valid cyc=%0d got=%b exp=0", cyc, bus.rsp_valid);
            end
         end else begin
            exp_ready = !bus.flush && (q.size() < DEPTH);
            exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 1);
            checks++;
            if (bus.req_ready !== exp_ready) begin
               errors++;
               $display("FAIL mon_req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready);
            end
            checks++;
            if (bus.rsp_valid !== exp_valid) begin
               errors++;
               $display("FAIL mon_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_valid);
            end
            if (exp_valid && bus.rsp_valid === 1'b1) begin
               checks++;
               if (bus.rsp_addr !== q[0].addr || bus.rsp_instr !== q[0].instr) begin
                  errors++;
                  $display("FAIL mon_rsp_beat cyc=%0d got=%0d/%h exp=%0d/%h", cyc,
                           bus.rsp_addr, bus.rsp_instr, q[0].addr, q[0].instr);
               end
            end
            if (bus.flush) begin
               q.delete();
            end else begin
               if (exp_valid && bus.rsp_valid && bus.rsp_ready) void'(q.pop_front());
               if (bus.req_valid && bus.req_ready) begin
                  e.addr  = bus.req_addr;
                  e.instr = mem_m[bus.req_addr];
                  e.acc   = cyc + 1;
                  q.push_back(e);
               end
            end
         end
      end
      if (bus.prog_we === 1'b1) mem_m[bus.prog_addr] = bus.prog_data;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
      checks++; if (bus.rsp_instr !== '0) begin errors++; $display("FAIL rst_rsp_instr got=%h exp=0", bus.rsp_instr); end
      checks++; if (bus.rsp_addr !== '0) begin errors++; $display("FAIL rst_rsp_addr got=%0d exp=0", bus.rsp_addr); end
      rst = 1'b0;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready); end
      bus.req_valid = 1'b1;
      bus.req_addr  = 5'd2;
      step();
      bus.req_valid = 1'b0;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_early got=%b exp=0", bus.rsp_valid); end
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== 32'h0020_81b3 || bus.rsp_addr !== 5'd2) begin
         errors++;
         $display("FAIL fetch2 got=%b/%h/%0d exp=1/002081b3/2", bus.rsp_valid, bus.rsp_instr, bus.rsp_addr);
      end
      step();
   endtask

   task automatic test_stream();
      for (int i = 0; i < 6; i++) begin
         bus.req_valid = (i < 4);
         bus.req_addr  = AW'(i);
         if (i < 4) begin
            checks++;
            if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, bus.req_ready); end
         end
         step();
         if (i >= 1 && i <= 4) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_addr !== AW'(i - 1) || bus.rsp_instr !== prog[i-1]) begin
               errors++;
               $display("FAIL stream_beat i=%0d got=%b/%0d/%h exp=1/%0d/%h", i, bus.rsp_valid,
                        bus.rsp_addr, bus.rsp_instr, i - 1, prog[i-1]);
            end
         end
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int nxt = 0;
      int got = 0;
      int guard = 0;
      bus.rsp_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         bus.req_valid = (nxt < 6);
         bus.req_addr  = AW'(nxt);
         if (bus.req_valid && bus.req_ready) nxt++;
         step();
      end
      checks++; if (nxt !== 3) begin errors++; $display("FAIL bp_accepted got=%0d exp=3", nxt); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", bus.req_ready); end
      bus.rsp_ready = 1'b1;
      while ((got < 6 || nxt < 6) && guard < 40) begin
         bus.req_valid = (nxt < 6);
         bus.req_addr  = AW'(nxt);
         if (bus.rsp_valid) begin
            checks++;
            if (bus.rsp_addr !== AW'(got)) begin errors++; $display("FAIL bp_order got=%0d exp=%0d", bus.rsp_addr, got); end
            got++;
         end
         if (bus.req_valid && bus.req_ready) nxt++;
         step();
         guard++;
      end
      bus.req_valid = 1'b0;
      checks++; if (got !== 6) begin errors++; $display("FAIL bp_drained got=%0d exp=6", got); end
   endtask

   task automatic test_flush();
      int nxt = 0;
      bus.rsp_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         bus.req_valid = (nxt < 3);
         bus.req_addr  = AW'(4 + nxt);
         if (bus.req_valid && bus.req_ready) nxt++;
         step();
      end
      checks++; if (nxt !== 3) begin errors++; $display("FAIL fl_fill got=%0d exp=3", nxt); end
      bus.flush     = 1'b1;
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_addr  = 5'd20;
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL fl_ready got=%b exp=0", bus.req_ready); end
      step();
      bus.flush = 1'b0;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_rsp_valid got=%b exp=0", bus.rsp_valid); end
      step();
      bus.req_valid = 1'b0;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL fl_early got=%b exp=0", bus.rsp_valid); end
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_addr !== 5'd20 || bus.rsp_instr !== NOP) begin
         errors++;
         $display("FAIL fl_next got=%b/%0d/%h exp=1/20/%h", bus.rsp_valid, bus.rsp_addr, bus.rsp_instr, NOP);
      end
      step();
   endtask

   task automatic test_collision();
      bus.prog_we = 1'b1; bus.prog_addr = 5'd7; bus.prog_data = 32'hAAAA_AAAA;
      step();
      bus.prog_data = 32'h5555_5555;
      bus.req_valid = 1'b1; bus.req_addr = 5'd7;
      step();
      bus.prog_we = 1'b0; bus.req_valid = 1'b0;
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== 32'hAAAA_AAAA) begin
         errors++; $display("FAIL coll_old got=%b/%h exp=1/aaaaaaaa", bus.rsp_valid, bus.rsp_instr);
      end
      bus.req_valid = 1'b1;
      step();
      bus.req_valid = 1'b0;
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== 32'h5555_5555 || bus.rsp_addr !== 5'd7) begin
         errors++; $display("FAIL coll_new got=%b/%h/%0d exp=1/55555555/7", bus.rsp_valid, bus.rsp_instr, bus.rsp_addr);
      end
      step();
   endtask

   task automatic test_async_reset();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_addr = 5'd1;
      step();
      bus.req_addr = 5'd3;
      step();
      bus.req_valid = 1'b0;
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_addr !== 5'd1) begin
         errors++; $display("FAIL ar_buffered got=%b/%0d exp=1/1", bus.rsp_valid, bus.rsp_addr);
      end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_drop got=%b exp=0", bus.rsp_valid); end
      checks++; if (bus.rsp_addr !== '0) begin errors++; $display("FAIL ar_addr got=%0d exp=0", bus.rsp_addr); end
      step();
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL ar_stale i=%0d got=%b exp=0", i, bus.rsp_valid); end
         step();
      end
      bus.req_valid = 1'b1; bus.req_addr = 5'd0;
      step();
      bus.req_valid = 1'b0;
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== prog[0]) begin
         errors++; $display("FAIL ar_mem_kept got=%b/%h exp=1/%h", bus.rsp_valid, bus.rsp_instr, prog[0]);
      end
      step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.req_valid = ($urandom_range(3) != 0);
         bus.req_addr  = AW'($urandom);
         bus.rsp_ready = ($urandom_range(2) != 0);
         bus.flush     = ($urandom_range(24) == 0);
         bus.prog_we   = ($urandom_range(5) == 0);
         bus.prog_addr = AW'($urandom);
         bus.prog_data = $urandom;
         step();
      end
      bus.req_valid = 1'b0; bus.flush = 1'b0; bus.prog_we = 1'b0; bus.rsp_ready = 1'b1;
   endtask

   task automatic test_drain();
      repeat (6) step();
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL drain got=%b exp=0", bus.rsp_valid); end
   endtask

   initial begin
      rst = 1'b1;
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.flush = 1'b0; bus.rsp_ready = 1'b1;
      bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      for (int i = 0; i < 2**AW; i++) begin
         bus.prog_we = 1'b1; bus.prog_addr = AW'(i); bus.prog_data = NOP;
         step();
      end
      for (int i = 0; i < 4; i++) begin
         bus.prog_addr = AW'(i); bus.prog_data = prog[i];
         step();
      end
      bus.prog_we = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_collision();
      test_async_reset();
      test_random();
      test_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_responder.md
# instr_fetch_responder

Instruction-side responder for the word-indexed program counter: accepts fetch requests carrying a PC value, reads the instruction word from an internal instruction memory, and returns it over a valid/ready response channel. A branch-taken redirect (driven from PCsrc) flushes all in-flight and buffered fetches. A write port loads the program before or between runs.

## Interface
- ADDR_WIDTH, 5: PC / word-address width; memory depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: instruction width.
- RSP_DEPTH, 3: response FIFO entries; must be ≥3 for one fetch per cycle.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_addr  in  ADDR_WIDTH  PC of instruction to fetch (word index).
- flush  in  1  branch taken; discard everything in flight.
- rsp_valid  out  1  response FIFO head valid.
- rsp_ready  in  1  consumer pops the head when rsp_valid && rsp_ready.
- rsp_instr  out  DATA_WIDTH  instruction at FIFO head.
- rsp_addr  out  ADDR_WIDTH  PC that produced rsp_instr.
- prog_we  in  1  program-load write enable.
- prog_addr  in  ADDR_WIDTH  load address.
- prog_data  in  DATA_WIDTH  load data.

## Operation
- Memory: 2**ADDR_WIDTH × DATA_WIDTH array, not reset, synchronous read, synchronous write via prog_*.
- Pipeline: stage S1 (read register: s1_valid, s1_addr, s1_data), then response FIFO.
- Accept: the read of mem[req_addr] is captured into S1 at the accept edge; s1_valid=1.
- Each edge with s1_valid=1 pushes S1 into the FIFO (space is guaranteed by credit rule).
- Credit rule: req_ready = !flush && (fifo_count + s1_valid) < RSP_DEPTH. Pop in the same cycle does not add credit (no combinational rsp_ready→req_ready path).
- Flush: at an edge with flush=1, s1_valid←0 and FIFO emptied; no request accepted that cycle (req_ready=0); a pop in that cycle is discarded with the rest.
- Read/write collision (prog_we with accepted request, same address): read returns the old word.
- Responses emerge strictly in request order; no reordering, no drops except by flush.
- rsp_instr/rsp_addr hold stable while rsp_valid && !rsp_ready.

## Timing
- Reset (async assert, edge-synchronous release): s1_valid=0, fifo_count=0, rsp_valid=0, rsp_instr=0, rsp_addr=0, req_ready=1 on first cycle after deassert (if flush=0).
- Latency: request accepted at edge N → rsp_valid=1 after edge N+1 (visible in cycle N+2 with rsp_ready continuously high, one per cycle).
- Throughput: one fetch per cycle sustained with RSP_DEPTH=3 and rsp_ready=1.
- Backpressure: rsp_ready held low → at most RSP_DEPTH responses stored, req_ready falls once fifo_count+s1_valid=RSP_DEPTH.
- Flush latency: rsp_valid=0 in the cycle after the flush edge; first post-flush request accepted in that cycle appears two edges later.
- Reset mid-operation: all in-flight fetches lost, memory contents retained.

## Structure
- Shared package (fetch_pkg): instr_t typedef (logic [31:0]), NOP constant 32'h0000_0013 for bench fill, default ADDR_WIDTH.
- Sub-module: rsp_fifo — synchronous FIFO (DEPTH, WIDTH=DATA_WIDTH+ADDR_WIDTH, async active-high reset, clear input driven by flush, count output).
- Memory array and S1 stage stay in the top module.

## Test plan
- Reset/load: write mem[0..3]=0x00500093,0x00a00113,0x002081b3,0x00000013, rst pulse → all outputs 0, req_ready=1; fetch addr 2 → rsp_instr=0x002081b3, rsp_addr=2 two edges later.
- Streaming: req addrs 0,1,2,3 back-to-back, rsp_ready=1 → four consecutive rsp beats in order, req_ready never low.
- Backpressure: rsp_ready=0, issue addrs 0..5 → exactly 3 accepted, req_ready=0 thereafter; release rsp_ready → responses 0,1,2 in order, then remaining requests accepted.
- Flush: fill with addrs 4,5,6, assert flush one cycle, then request addr 20 → no response for 4/5/6, next rsp_addr=20; req_ready=0 during flush cycle.
- Collision: mem[7]=0xAAAA_AAAA, same edge prog_we writes 0x5555_5555 to 7 and fetch 7 accepted → rsp 0xAAAA_AAAA; refetch → 0x5555_5555.
- Async reset mid-stream: assert rst between edges with 2 responses buffered → rsp_valid drops immediately, no stale beat after release.
